// File: rtl/sorter_frame_loader.sv
// Streaming loader that fills a padded frame buffer for sorter_top, launches it and times its completion.
// Optional SORTER_LOADER_STATS_EN adds saturating job and error counters.
module sorter_frame_loader #(
    parameter int DATAWIDTH      = 8,
    parameter int MAX_DATALENGTH = 32,
    parameter int LANES          = 4,
    parameter int MAX_GROUP      = 8,
    parameter int SORT_LATENCY   = 4,
    parameter int LEN_W          = $clog2(MAX_DATALENGTH + 1),
    parameter int GRP_W          = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                cfg_valid_i,
    output logic                                cfg_ready_o,
    input  logic [LEN_W-1:0]                    cfg_length_i,
    input  logic [GRP_W-1:0]                    cfg_group_i,
    input  logic                                cfg_sign_i,
    output logic                                cfg_err_o,
    input  logic                                s_valid_i,
    output logic                                s_ready_o,
    input  logic [LANES*DATAWIDTH-1:0]          s_data_i,
    input  logic [LANES-1:0]                    s_keep_i,
    input  logic                                s_last_i,
    output logic [MAX_DATALENGTH*DATAWIDTH-1:0] sort_x_o,
    output logic [LEN_W-1:0]                    sort_length_o,
    output logic [GRP_W-1:0]                    sort_group_o,
    output logic                                sort_sign_o,
    output logic                                sort_start_o,
    output logic                                done_o,
    output logic                                len_err_o,
    output logic                                busy_o,
`ifdef SORTER_LOADER_STATS_EN
    output logic [15:0]                         stat_jobs_o,
    output logic [15:0]                         stat_errs_o,
`endif
    output logic [1:0]                          dbg_state
);

    typedef enum logic [1:0] {IDLE, FILL, ISSUE, WAIT} state_t;

    localparam int CNT_W = $clog2(SORT_LATENCY + 1);
    localparam int CW    = LEN_W + 1;
    localparam logic [DATAWIDTH-1:0] MIN_SIGNED = {1'b1, {(DATAWIDTH-1){1'b0}}};

    // Handshakes: a transfer happens on a rising clk_i edge where valid and
    // ready are both high; ready depends on state only, never on valid.
    state_t               state, state_next;
    logic [LEN_W-1:0]     wptr;
    logic [CNT_W-1:0]     cnt;
    logic                 cfg_bad, cfg_fire, beat_fire;
    logic [CW-1:0]        beat_count, wptr_sum;
    logic [DATAWIDTH-1:0] pad;

    assign cfg_bad   = (cfg_group_i == '0) || (cfg_group_i > GRP_W'(MAX_GROUP)) ||
                       (cfg_length_i > LEN_W'(MAX_DATALENGTH));
    assign cfg_fire  = cfg_valid_i && cfg_ready_o && !cfg_bad;
    assign cfg_err_o = cfg_valid_i && cfg_ready_o && cfg_bad;
    assign beat_fire = s_valid_i && s_ready_o;
    assign pad       = cfg_sign_i ? MIN_SIGNED : '0;
    assign wptr_sum  = {1'b0, wptr} + beat_count;
    // Unsaturated sum, so an overrun of a full-length job is still flagged.
    assign len_err_o = beat_fire && s_last_i && (wptr_sum != {1'b0, sort_length_o});
    assign dbg_state = state;

    always_comb begin
        beat_count = '0;
        for (int j = 0; j < LANES; j++) begin
            beat_count = beat_count + CW'(s_keep_i[j]);
        end
    end

    always_comb begin
        state_next   = state;
        cfg_ready_o  = 1'b0;
        s_ready_o    = 1'b0;
        sort_start_o = 1'b0;
        done_o       = 1'b0;
        busy_o       = 1'b1;
        case (state)
            IDLE: begin
                cfg_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (cfg_valid_i && !cfg_bad) begin
                    state_next = (cfg_length_i == '0) ? ISSUE : FILL;
                end
            end
            FILL: begin
                s_ready_o = 1'b1;
                if (s_valid_i && s_last_i) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                sort_start_o = 1'b1;
                state_next   = WAIT;
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    done_o     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            wptr          <= '0;
            cnt           <= '0;
            sort_x_o      <= '0;
            sort_length_o <= '0;
            sort_group_o  <= '0;
            sort_sign_o   <= 1'b0;
        end else begin
            state <= state_next;
            if (cfg_fire) begin
                sort_length_o <= cfg_length_i;
                sort_group_o  <= cfg_group_i;
                sort_sign_o   <= cfg_sign_i;
                wptr          <= '0;
                for (int i = 0; i < MAX_DATALENGTH; i++) begin
                    sort_x_o[i*DATAWIDTH +: DATAWIDTH] <= pad;
                end
            end
            if (beat_fire) begin
                // Each entry picks the lane that lands on it; lanes past the length are dropped.
                for (int i = 0; i < MAX_DATALENGTH; i++) begin
                    for (int j = 0; j < LANES; j++) begin
                        if (s_keep_i[j] && ({1'b0, wptr} + CW'(j) == CW'(i)) &&
                            (CW'(i) < {1'b0, sort_length_o})) begin
                            sort_x_o[i*DATAWIDTH +: DATAWIDTH] <= s_data_i[j*DATAWIDTH +: DATAWIDTH];
                        end
                    end
                end
                wptr <= (wptr_sum > CW'(MAX_DATALENGTH)) ? LEN_W'(MAX_DATALENGTH)
                                                         : wptr_sum[LEN_W-1:0];
            end
            if (sort_start_o) begin
                cnt <= CNT_W'(SORT_LATENCY);
            end else if (state == WAIT) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

`ifdef SORTER_LOADER_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_jobs_o <= '0;
            stat_errs_o <= '0;
        end else begin
            if (sort_start_o && stat_jobs_o != 16'hFFFF) begin
                stat_jobs_o <= stat_jobs_o + 16'd1;
            end
            if ((len_err_o || cfg_err_o) && stat_errs_o != 16'hFFFF) begin
                stat_errs_o <= stat_errs_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sorter_frame_loader.sv
// Scoreboard bench for sorter_frame_loader: directed jobs push expected start/done/error
// events; a monitor pops and compares them whenever the DUT pulses an output.
module tb_sorter_frame_loader;

    localparam int DW    = 8;
    localparam int N     = 32;
    localparam int LANES = 4;
    localparam int LAT   = 4;
    localparam int LEN_W = 6;
    localparam int GRP_W = 4;
    localparam int XW    = N * DW;
    localparam int SW    = XW + LEN_W + GRP_W + 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  cfg_valid = 1'b0;
    logic [LEN_W-1:0]      cfg_length = '0;
    logic [GRP_W-1:0]      cfg_group = '0;
    logic                  cfg_sign = 1'b0;
    logic                  s_valid = 1'b0;
    logic [LANES*DW-1:0]   s_data = '0;
    logic [LANES-1:0]      s_keep = '0;
    logic                  s_last = 1'b0;
    logic                  cfg_ready, cfg_err, s_ready, sort_sign, sort_start, done, len_err, busy;
    logic [XW-1:0]         sort_x;
    logic [LEN_W-1:0]      sort_length;
    logic [GRP_W-1:0]      sort_group;
    logic [1:0]            dbg_state;
`ifdef SORTER_LOADER_STATS_EN
    logic [15:0]           stat_jobs, stat_errs;
`endif

    sorter_frame_loader dut (
        .clk_i(clk), .rst_i(rst),
        .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_length_i(cfg_length),
        .cfg_group_i(cfg_group), .cfg_sign_i(cfg_sign), .cfg_err_o(cfg_err),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data), .s_keep_i(s_keep),
        .s_last_i(s_last), .sort_x_o(sort_x), .sort_length_o(sort_length),
        .sort_group_o(sort_group), .sort_sign_o(sort_sign), .sort_start_o(sort_start),
        .done_o(done), .len_err_o(len_err), .busy_o(busy),
`ifdef SORTER_LOADER_STATS_EN
        .stat_jobs_o(stat_jobs), .stat_errs_o(stat_errs),
`endif
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int tests = 0;
    int failed = 0;
    logic [SW-1:0] start_q[$];
    logic [31:0]   start_cyc_q[$];
    logic [31:0]   done_q[$];
    logic [31:0]   lenerr_q[$];
    logic [31:0]   cfgerr_q[$];

    logic [LANES*DW-1:0] bd[0:15];
    logic [LANES-1:0]    bk[0:15];
    int                  nb;
    logic [XW-1:0]       exp_x;
    logic [SW-1:0]       saved;

    task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        tests++;
        failed++;
        $display("FAIL %s: got unexpected pulse at cycle %0d, required none", name, cyc);
    endtask

    function automatic logic [SW-1:0] outs();
        return {sort_x, sort_length, sort_group, sort_sign};
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (sort_start) begin
                    if (start_q.size() == 0) unexpected("start");
                    else begin
                        check("start_frame", outs(), start_q.pop_front());
                        check("start_cycle", SW'(cyc), SW'(start_cyc_q.pop_front()));
                    end
                end
                if (done) begin
                    if (done_q.size() == 0) unexpected("done");
                    else check("done_cycle", SW'(cyc), SW'(done_q.pop_front()));
                end
                if (len_err) begin
                    if (lenerr_q.size() == 0) unexpected("len_err");
                    else check("len_err_cycle", SW'(cyc), SW'(lenerr_q.pop_front()));
                end
                if (cfg_err) begin
                    if (cfgerr_q.size() == 0) unexpected("cfg_err");
                    else check("cfg_err_cycle", SW'(cyc), SW'(cfgerr_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver tasks (enter and leave just after a rising edge) ----------------
    task automatic send_cfg(input int len, input int grp, input int sgn, input bit rej, output int acc);
        cfg_valid  = 1'b1;
        cfg_length = LEN_W'(len);
        cfg_group  = GRP_W'(grp);
        cfg_sign   = sgn[0];
        acc = -1;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (cfg_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) check("cfg_timeout", SW'(0), SW'(1));
        else if (rej) cfgerr_q.push_back(acc);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [LANES*DW-1:0] d, input logic [LANES-1:0] k,
                             input bit last, input bit exp_lerr, output int m);
        s_valid = 1'b1;
        s_data  = d;
        s_keep  = k;
        s_last  = last;
        m = -1;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (s_ready) begin
                m = cyc;
                break;
            end
        end
        if (m < 0) check("beat_timeout", SW'(0), SW'(1));
        else if (last && exp_lerr) lenerr_q.push_back(m);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_job(input int len, input int grp, input int sgn, input bit exp_lerr);
        int acc;
        int m;
        send_cfg(len, grp, sgn, 1'b0, acc);
        m = acc;
        if (len != 0) begin
            check("fill_ready", SW'(s_ready), SW'(1));
            for (int b = 0; b < nb; b++) send_beat(bd[b], bk[b], b == nb - 1, exp_lerr, m);
        end
        start_q.push_back({exp_x, LEN_W'(len), GRP_W'(grp), sgn[0]});
        start_cyc_q.push_back(m + 1);
        done_q.push_back(m + 1 + LAT);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (done_q.size() == 0 && start_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("done_timeout", SW'(0), SW'(1));
        check("ready_after_done", SW'({cfg_ready, busy}), SW'(2'b10));
        @(posedge clk);
        #1;
    endtask

    task automatic fill_beats(input int nbeats, input int base);
        nb = nbeats;
        for (int b = 0; b < nbeats; b++) begin
            bk[b] = 4'hF;
            for (int j = 0; j < LANES; j++) bd[b][j*DW +: DW] = DW'(base + b * LANES + j);
        end
    endtask

    task automatic set_exp(input int n_data, input int base, input logic [DW-1:0] padv);
        for (int i = 0; i < N; i++) exp_x[i*DW +: DW] = (i < n_data) ? DW'(base + i) : padv;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int acc;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cfg_ready", SW'(cfg_ready), SW'(1));
        check("rst_pulses", SW'({s_ready, sort_start, done, len_err, cfg_err, busy}), SW'(0));
        check("rst_outputs", outs(), SW'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 20 unsigned elements 0..19, zero padding
        fill_beats(5, 0);
        set_exp(20, 0, 8'h00);
        run_job(20, 1, 0, 1'b0);
        wait_idle();

        // 6 signed elements over a partial final beat, 0x80 padding
        nb = 2;
        bd[0] = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        bk[0] = 4'b1111;
        bd[1] = {8'hEE, 8'hEE, 8'hA5, 8'hA4};
        bk[1] = 4'b0011;
        set_exp(6, 8'hA0, 8'h80);
        run_job(6, 3, 1, 1'b0);
        wait_idle();

        // short job: 4 of 8 elements
        fill_beats(1, 8'h11);
        set_exp(4, 8'h11, 8'h00);
        run_job(8, 2, 0, 1'b1);
        wait_idle();

        // long job: 12 elements into length 8, tail dropped
        fill_beats(3, 8'h20);
        set_exp(8, 8'h20, 8'h00);
        run_job(8, 2, 0, 1'b1);
        wait_idle();

        // rejected configurations leave everything untouched
        saved = {exp_x, LEN_W'(8), GRP_W'(2), 1'b0};
        send_cfg(4, 0, 1, 1'b1, acc);
        check("rej_g0_busy", SW'(busy), SW'(0));
        check("rej_g0_outs", outs(), saved);
        send_cfg(4, 9, 1, 1'b1, acc);
        check("rej_g9_busy", SW'(busy), SW'(0));
        check("rej_g9_outs", outs(), saved);
        send_cfg(33, 1, 1, 1'b1, acc);
        check("rej_l33_busy", SW'(busy), SW'(0));
        check("rej_l33_outs", outs(), saved);

        // zero-length signed job: all pad, start right after acceptance
        set_exp(0, 0, 8'h80);
        run_job(0, 1, 1, 1'b0);
        wait_idle();

        // reset during WAIT aborts the job without a done pulse
        fill_beats(1, 8'h40);
        set_exp(4, 8'h40, 8'h00);
        run_job(4, 1, 0, 1'b0);
        for (int t = 0; t < 16 && start_q.size() != 0; t++) @(negedge clk);
        @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort_cfg_ready", SW'(cfg_ready), SW'(1));
        check("abort_pulses", SW'({s_ready, sort_start, done, len_err, busy}), SW'(0));
        check("abort_outputs", outs(), SW'(0));
        done_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // full 32-element signed job with the largest legal group count
        fill_beats(8, 8'h60);
        set_exp(32, 8'h60, 8'h80);
        run_job(32, 8, 1, 1'b0);
        wait_idle();

`ifdef SORTER_LOADER_STATS_EN
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        set_exp(0, 0, 8'h00);
        for (int r = 0; r < 3; r++) begin
            run_job(0, 1, 0, 1'b0);
            wait_idle();
        end
        send_cfg(5, 0, 0, 1'b1, acc);
        @(posedge clk);
        #1;
        check("stat_jobs", SW'(stat_jobs), SW'(3));
        check("stat_errs", SW'(stat_errs), SW'(1));
`endif

        repeat (4) @(posedge clk);
        #1;
        check("pending_start", SW'(start_q.size()), SW'(0));
        check("pending_done", SW'(done_q.size()), SW'(0));
        check("pending_len_err", SW'(lenerr_q.size()), SW'(0));
        check("pending_cfg_err", SW'(cfgerr_q.size()), SW'(0));
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

endmodule
